sipo_frame_loader: RTL and testbench
====================================

// Module: sipo_frame_loader
// PURPOSE
//   Serial-in/parallel-out frame assembler sitting directly upstream of the 35-bit PIPO register.
//   Collects WIDTH serial bits, LSB first, into a frame.
//   Presents the completed frame on a registered bus with a valid/ready handshake.
//   Back-pressures the serial source while a completed frame awaits hand-off.
// PARAMETERS
//   WIDTH    35   frame width in bits (= PIPO register width)
//   CNT_W    6    bit_count width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk          in   1      single system clock, rising edge
//   rst          in   1      synchronous reset, active-low
//   bit_in       in   1      serial data bit
//   bit_valid    in   1      bit_in is valid this cycle
//   bit_ready    out  1      loader accepts a bit this cycle
//   frame_abort  in   1      discard partial/pending frame, return to IDLE
//   frame_out    out  WIDTH  last completed frame (drives PIPO parallel_in)
//   frame_valid  out  1      frame_out holds a new, un-acknowledged frame
//   frame_ready  in   1      downstream takes the frame this cycle
//   bit_count    out  CNT_W  data bits accepted in the current frame
//   parity_err   out  1      one-cycle pulse on parity failure (tied 0 without PARITY_CHECK_EN)
// BEHAVIOUR
//   - Reset: rst==0 at a posedge forces state=IDLE, bit_count=0, shift reg=0, frame_out=0,
//     frame_valid=0, parity_err=0. bit_ready=1 from the first cycle after reset.
//   - Accept = bit_valid & bit_ready. Shift: sr <= {bit_in, sr[WIDTH-1:1]}. First bit ends in frame_out[0].
//   - States: IDLE, SHIFT, PARITY (macro only), FULL.
//   - IDLE: bit_ready=1. On accept: shift, bit_count=1, go to SHIFT.
//   - SHIFT: bit_ready=1. Each accept shifts and increments bit_count.
//     The accept with bit_count==WIDTH-1 goes to FULL (or PARITY) and clears bit_count to 0.
//   - FULL entry: frame_out <= assembled value; frame_valid=1 the cycle after the last bit is accepted.
//     Latency is 1 clk.
//   - FULL: bit_ready=0; frame_out and frame_valid held stable.
//     frame_valid & frame_ready: frame_valid=0 next cycle, state goes to IDLE.
//     No new bit is accepted in that same cycle.
//   - Bits offered while bit_ready=0 are dropped with no state change.
//   - frame_out changes only on frame completion.
//     It holds the last frame after hand-off, until the next completion or reset.
//   - frame_abort (priority over bit_valid and frame_ready):
//     next state IDLE, bit_count=0, frame_valid=0, frame_out unchanged.
//   - Reset has priority over everything. Reset mid-frame discards the partial frame and clears frame_out.
//   - bit_count saturation: never exceeds WIDTH-1. The WIDTH-th accept wraps it to 0.
// CONFIGURATION
//   PARITY_CHECK_EN defined:
//     - After WIDTH data bits the state is PARITY; bit_ready=1; bit_count stays 0.
//     - The next accepted bit is even parity: ^{data,bit} must equal 0.
//     - Pass: load frame_out, frame_valid=1, go to FULL.
//     - Fail: parity_err=1 for one cycle, frame_out and frame_valid unchanged, go to IDLE.
//   PARITY_CHECK_EN undefined:
//     - No PARITY state; frame completes on the WIDTH-th bit.
//     - parity_err is constant 0.
// TESTING
//   1. rst=0 for 2 clks with bit_valid=1 -> frame_out=0, frame_valid=0, bit_count=0, parity_err=0, bit_ready=1.
//   2. 35 bits of 35'h555555555 LSB first, frame_ready=0 -> frame_valid=1 exactly 1 clk after the 35th
//      accept; frame_out=35'h555555555; bit_count=0.
//   3. Hold frame_ready=0 for 10 clks with bit_valid=1 -> bit_ready=0, frame_out stable, bit_count=0.
//      Then frame_ready=1 for 1 clk -> frame_valid=0 and bit_ready=1 the next cycle.
//   4. 20 bits, then frame_abort=1 together with bit_valid=1 -> bit_count=0, no frame_valid.
//      Then 35 ones -> frame_out=35'h7FFFFFFFF.
//   5. rst=0 after 17 bits of a frame -> bit_count=0, frame_out=0, frame_valid stays 0.
//      Then a full frame of 35'h000000001 -> frame_out=35'h000000001.
//   6. (PARITY_CHECK_EN) 35 ones + parity bit 0 -> parity_err pulse, no frame_valid.
//      35 ones + parity bit 1 -> frame_valid=1, frame_out=35'h7FFFFFFFF.

Source files
------------

// File: rtl/sipo_frame_loader_if.sv
// Serial-bit and parallel-frame handshake bundle for sipo_frame_loader.
// The slave modport is the loader side, the master modport the source/sink side.
interface sipo_frame_loader_if #(
    parameter int WIDTH = 35,
    parameter int CNT_W = 6
);
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             frame_abort;
    logic [WIDTH-1:0] frame_out;
    logic             frame_valid;
    logic             frame_ready;
    logic [CNT_W-1:0] bit_count;
    logic             parity_err;

    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready,
        input  frame_abort,
        output frame_out,
        output frame_valid,
        input  frame_ready,
        output bit_count,
        output parity_err
    );

    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready,
        output frame_abort,
        input  frame_out,
        input  frame_valid,
        output frame_ready,
        input  bit_count,
        input  parity_err
    );
endinterface

// File: rtl/sipo_frame_loader.sv
// Serial-in/parallel-out frame assembler, LSB first, with valid/ready hand-off.
// Define PARITY_CHECK_EN to require a trailing even-parity bit per frame.
module sipo_frame_loader #(
    parameter int WIDTH = 35,
    parameter int CNT_W = 6
) (
    input logic               clk,
    input logic               rst,
    sipo_frame_loader_if.slave bus
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        FULL   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd3
    } state_t;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] fout_q;
    logic [WIDTH-1:0] fout_d;
    logic             fval_q;
    logic             fval_d;
    logic             perr_q;
    logic             perr_d;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             sr_unused;

    assign shifted   = {bus.bit_in, sr_q[WIDTH-1:1]};
    assign last_bit  = (cnt_q == LAST);
    assign sr_unused = sr_q[0];

    assign bus.bit_ready   = (state_q != FULL);
    assign bus.frame_out   = fout_q;
    assign bus.frame_valid = fval_q;
    assign bus.bit_count   = cnt_q;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err  = perr_q;
`else
    assign bus.parity_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            fout_q <= '0;
            fval_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            fout_q <= fout_d;
            fval_q <= fval_d;
            perr_q <= perr_d;
        end
    end

    // Abort wins over both handshakes; frame_out keeps the last good frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        fout_d  = fout_q;
        fval_d  = fval_q;
        perr_d  = 1'b0;
        if (bus.frame_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            fval_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, SHIFT: begin
                    if (bus.bit_valid) begin
                        sr_d = shifted;
                        if (last_bit) begin
                            cnt_d = '0;
`ifdef PARITY_CHECK_EN
                            state_d = PARITY;
`else
                            state_d = FULL;
                            fout_d  = shifted;
                            fval_d  = 1'b1;
`endif
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = SHIFT;
                        end
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    if (bus.bit_valid) begin
                        if (^{sr_q, bus.bit_in} == 1'b0) begin
                            fout_d  = sr_q;
                            fval_d  = 1'b1;
                            state_d = FULL;
                        end else begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
`endif
                FULL: begin
                    if (fval_q && bus.frame_ready) begin
                        fval_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_frame_loader.sv
// Scoreboard bench for sipo_frame_loader: frames queued on send, popped on valid.
// Parity cases compile in when PARITY_CHECK_EN is defined.
module tb_sipo_frame_loader;

    localparam int W = 35;
    localparam int C = 6;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [W-1:0] exp_q[$];
    logic prev_v;

    sipo_frame_loader_if #(.WIDTH(W), .CNT_W(C)) bus ();

    sipo_frame_loader #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every new frame_valid assertion must match the oldest queued frame.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.frame_valid && !prev_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame got=%h expected=none",
                             bus.frame_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.frame_out !== e) begin
                        errors++;
                        $display("FAIL frame_data got=%h expected=%h",
                                 bus.frame_out, e);
                    end
                end
            end
            prev_v = bus.frame_valid;
        end
    end

    task automatic send_bit(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] v);
        exp_q.push_back(v);
        for (int i = 0; i < W; i++) begin
            send_bit(v[i]);
        end
`ifdef PARITY_CHECK_EN
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid got=%b expected=0", bus.frame_valid);
        end
        send_bit(^v);
`endif
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.bit_count !== 6'd0) begin
            errors++;
            $display("FAIL latency valid=%b cnt=%0d expected valid=1 cnt=0",
                     bus.frame_valid, bus.bit_count);
        end
    endtask

    task automatic take_frame();
        bus.frame_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ready = 1'b0;
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL handoff valid=%b ready=%b expected valid=0 ready=1",
                     bus.frame_valid, bus.bit_ready);
        end
    endtask

    task automatic test_reset();
        rst             = 1'b0;
        bus.bit_in      = 1'b1;
        bus.bit_valid   = 1'b1;
        bus.frame_abort = 1'b0;
        bus.frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.frame_out !== '0 || bus.frame_valid !== 1'b0 ||
            bus.bit_count !== 6'd0 || bus.parity_err !== 1'b0 ||
            bus.bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset out=%h v=%b cnt=%0d perr=%b rdy=%b expected 0/0/0/0/1",
                     bus.frame_out, bus.frame_valid, bus.bit_count,
                     bus.parity_err, bus.bit_ready);
        end
        bus.bit_valid = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        send_frame(35'h555555555);
        checks++;
        if (bus.frame_out !== 35'h555555555) begin
            errors++;
            $display("FAIL frame_555 got=%h expected=555555555", bus.frame_out);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        held = bus.frame_out;
        for (int i = 0; i < 10; i++) begin
            bus.bit_in    = i[0];
            bus.bit_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (bus.bit_ready !== 1'b0 || bus.frame_out !== held ||
                bus.bit_count !== 6'd0 || bus.frame_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure rdy=%b out=%h cnt=%0d v=%b expected 0/%h/0/1",
                         bus.bit_ready, bus.frame_out, bus.bit_count,
                         bus.frame_valid, held);
            end
        end
        take_frame();
        bus.bit_valid = 1'b0;
        checks++;
        if (bus.bit_count !== 6'd0) begin
            errors++;
            $display("FAIL handoff_no_accept cnt=%0d expected=0", bus.bit_count);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 20; i++) begin
            send_bit(1'(i % 3 == 0));
        end
        checks++;
        if (bus.bit_count !== 6'd20) begin
            errors++;
            $display("FAIL count20 got=%0d expected=20", bus.bit_count);
        end
        bus.frame_abort = 1'b1;
        bus.bit_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_abort = 1'b0;
        bus.bit_valid   = 1'b0;
        checks++;
        if (bus.bit_count !== 6'd0 || bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort cnt=%0d v=%b expected cnt=0 v=0",
                     bus.bit_count, bus.frame_valid);
        end
        send_frame(35'h7FFFFFFFF);
        take_frame();
    endtask

    task automatic test_abort_full();
        logic [W-1:0] v;
        v = 35'({$urandom(), $urandom()});
        send_frame(v);
        bus.frame_abort = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_abort = 1'b0;
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.frame_out !== v ||
            bus.bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_full v=%b out=%h rdy=%b expected 0/%h/1",
                     bus.frame_valid, bus.frame_out, bus.bit_ready, v);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 17; i++) begin
            send_bit(1'b1);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checks++;
        if (bus.bit_count !== 6'd0 || bus.frame_out !== '0 ||
            bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid cnt=%0d out=%h v=%b expected 0/0/0",
                     bus.bit_count, bus.frame_out, bus.frame_valid);
        end
        send_frame(35'h000000001);
        take_frame();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            send_frame(35'({$urandom(), $urandom()}));
            take_frame();
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        for (int i = 0; i < W; i++) begin
            send_bit(1'b1);
        end
        send_bit(1'b0);
        checks++;
        if (bus.parity_err !== 1'b1 || bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad perr=%b v=%b expected perr=1 v=0",
                     bus.parity_err, bus.frame_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_pulse perr=%b expected=0", bus.parity_err);
        end
        send_frame(35'h7FFFFFFFF);
        take_frame();
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        prev_v = 1'b0;
        test_reset();
        test_frame();
        test_backpressure();
        test_abort();
        test_abort_full();
        test_reset_mid();
        test_back_to_back();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_frames got=%0d pending expected=0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
